// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM state encoding and the
// bubble instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_READY = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register for the fetch stage: reset load, sequential
// increment and redirect load (redirect has priority).
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  inc_en,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] pc_q,
  output logic [DATA_WIDTH-1:0] pc_plus_4
);

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_plus_4 = pc_q + DATA_WIDTH'(4);

  // PC update: redirect load beats increment, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load_en) begin
      pc_q <= load_val;
    end else if (inc_en) begin
      pc_q <= pc_plus_4;
    end else begin
      pc_q <= pc_q;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined RV32I core. Issues one instruction-memory read
// at a time, holds the returned word until the hazard unit releases it and
// inserts NOP bubbles while a read is outstanding. Responses made stale by a
// redirect from Execute are discarded via kill_q.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the sticky
// FetchMisalignF output flagging redirect targets with nonzero low bits.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PC_plus_4F,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  FetchMisalignF,
`endif
  output logic                  FetchValidF
);

  import fetch_pkg::*;

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  kill_q, kill_d;
  logic                  instr_load;
  logic                  pc_load, pc_inc;
  logic [DATA_WIDTH-1:0] pc_q, pc_plus_4;
  logic [DATA_WIDTH-1:0] target_aligned;

  // Low target bits are never stored: the PC stays word aligned.
  assign target_aligned = {PCTargetE[DATA_WIDTH-1:2], 2'b00};

  pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (pc_load),
    .inc_en    (pc_inc),
    .load_val  (target_aligned),
    .pc_q      (pc_q),
    .pc_plus_4 (pc_plus_4)
  );

  // Next-state, request and PC-control decode; redirect outranks stall.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    instr_load = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        state_d   = ST_WAIT;
        if (PCSrcE) begin
          // The request just issued now targets the wrong PC.
          pc_load = 1'b1;
          kill_d  = 1'b1;
        end else begin
          kill_d  = kill_q;
        end
      end
      ST_WAIT: begin
        if (PCSrcE) begin
          pc_load = 1'b1;
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            instr_load = 1'b1;
            state_d    = ST_READY;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_READY: begin
        if (PCSrcE) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else if (!StallF) begin
          // Fetch the next sequential word while advancing the PC.
          imem_req  = 1'b1;
          imem_addr = pc_plus_4;
          pc_inc    = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_RESET;
        kill_d  = 1'b0;
      end
    endcase
  end

  // FSM state, kill flag and held instruction word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (instr_load) begin
        instr_q <= imem_rdata;
      end else begin
        instr_q <= instr_q;
      end
    end
  end

  assign FetchValidF = (state_q == ST_READY);
  assign InstrF      = FetchValidF ? instr_q : NOP_INSTR;
  assign PCF         = pc_q;
  assign PC_plus_4F  = pc_plus_4;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  // Sticky flag: any accepted redirect to a non-word-aligned target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if ((state_q != ST_RESET) && PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end else begin
      misalign_q <= misalign_q;
    end
  end

  assign FetchMisalignF = misalign_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE[1:0];
`endif

endmodule
